// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared FSM states, mode encodings and width helper for jam_search
package jam_pkg;

  typedef enum logic [2:0] {IDLE, ACC, CMP, FIND, SWAP, REV, DONE} jam_state_e;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // Wide enough that N entries of all-ones cost can never wrap.
  function automatic int sum_width(input int n, input int cw);
    return cw + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/jam_search_if.sv
// rtl/jam_search_if.sv - cost-table read bus: registered W/J out, combinational Cost back
interface jam_search_if #(
  parameter int N  = 8,
  parameter int CW = 7
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] W;
  logic [IW-1:0] J;
  logic [CW-1:0] Cost;

  modport master (output W, output J, input Cost);
  modport slave  (input W, input J, output Cost);
endinterface

// File: rtl/jam_perm_next.sv
// rtl/jam_perm_next.sv - permutation register and lexicographic next-permutation sequencer
module jam_perm_next
  import jam_pkg::*;
#(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_i,
  input  logic                 step_i,
  output logic [N-1:0][IW-1:0] perm_o,
  output logic                 done_o,
  output logic                 last_o
);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] ONE      = IW'(1);

  jam_state_e           state_q;
  logic [N-1:0][IW-1:0] perm_q;
  logic [IW-1:0]        i_q, j_q, sel_q, f_q, b_q;
  logic                 have_q;

  always_comb begin
    last_o = 1'b1;
    for (int k = 0; k < N - 1; k++)
      if (perm_q[k] < perm_q[k+1]) last_o = 1'b0;
  end

  assign perm_o = perm_q;
  assign done_o = (state_q == REV) && (f_q >= b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int k = 0; k < N; k++) perm_q[k] <= IW'(k);
      i_q     <= '0;
      j_q     <= '0;
      sel_q   <= '0;
      f_q     <= '0;
      b_q     <= '0;
      have_q  <= 1'b0;
    end else if (init_i) begin
      state_q <= IDLE;
      for (int k = 0; k < N; k++) perm_q[k] <= IW'(k);
    end else begin
      case (state_q)
        IDLE: if (step_i) begin
          i_q     <= IW'(N - 2);
          state_q <= FIND;
        end
        // Caller never steps from the last permutation, so a pivot always exists.
        FIND: if (perm_q[i_q] < perm_q[i_q + ONE]) begin
          j_q     <= LAST_IDX;
          have_q  <= 1'b0;
          state_q <= SWAP;
        end else begin
          i_q <= i_q - ONE;
        end
        SWAP: if (j_q == i_q) begin
          perm_q[i_q]   <= perm_q[sel_q];
          perm_q[sel_q] <= perm_q[i_q];
          f_q     <= i_q + ONE;
          b_q     <= LAST_IDX;
          state_q <= REV;
        end else begin
          if ((perm_q[j_q] > perm_q[i_q]) && (!have_q || (perm_q[j_q] < perm_q[sel_q]))) begin
            sel_q  <= j_q;
            have_q <= 1'b1;
          end
          j_q <= j_q - ONE;
        end
        REV: if (f_q < b_q) begin
          perm_q[f_q] <= perm_q[b_q];
          perm_q[b_q] <= perm_q[f_q];
          f_q <= f_q + ONE;
          b_q <= b_q - ONE;
        end else begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/jam_search.sv
// rtl/jam_search.sv - exhaustive job-assignment search; define JAM_BEST_PERM_EN to add best_perm
module jam_search
  import jam_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 7,
  parameter int MW = 16,
  localparam int IW = $clog2(N),
  localparam int SW = sum_width(N, CW)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            start,
  input  logic            mode,
  jam_search_if.master    cost_bus,
  output logic [MW-1:0]   MatchCount,
  output logic [SW-1:0]   BestCost,
  output logic            Valid
`ifdef JAM_BEST_PERM_EN
  ,
  output logic [N*IW-1:0] best_perm
`endif
);
  localparam logic [3:0] LAST_CYC = 4'(N);
  localparam logic [3:0] LAST_W   = 4'(N - 1);

  jam_state_e           state_q;
  logic                 mode_q;
  logic [3:0]           cnt_q;
  logic [IW-1:0]        w_q, j_q;
  logic [CW-1:0]        cost_q;
  logic [SW-1:0]        sum_q, best_q;
  logic [MW-1:0]        match_q;
  logic                 valid_q;
  logic                 init, step, perm_done, perm_last, better, tie;
  logic [N-1:0][IW-1:0] perm;

  assign init   = start && ((state_q == IDLE) || (state_q == DONE));
  assign step   = (state_q == CMP) && !perm_last;
  assign better = (mode_q == MODE_MAX) ? (sum_q > best_q) : (sum_q < best_q);
  assign tie    = (sum_q == best_q);

  jam_perm_next #(.N(N)) u_perm (
    .clk    (CLK),
    .rst_n  (RST_N),
    .init_i (init),
    .step_i (step),
    .perm_o (perm),
    .done_o (perm_done),
    .last_o (perm_last)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      mode_q  <= MODE_MIN;
      cnt_q   <= '0;
      w_q     <= '0;
      j_q     <= '0;
      cost_q  <= '0;
      sum_q   <= '0;
      best_q  <= '0;
      match_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          mode_q  <= mode;
          best_q  <= (mode == MODE_MAX) ? '0 : '1;
          match_q <= '0;
          valid_q <= 1'b0;
          w_q     <= '0;
          j_q     <= '0;
          cnt_q   <= '0;
          sum_q   <= '0;
          state_q <= ACC;
        end
        // Cost is registered before the add; cycle 0 has nothing to add, cycle N adds the last entry.
        ACC: begin
          cost_q <= cost_bus.Cost;
          if (cnt_q != 4'd0) sum_q <= sum_q + SW'(cost_q);
          if (cnt_q < LAST_W) begin
            w_q <= w_q + IW'(1);
            j_q <= perm[w_q + IW'(1)];
          end
          if (cnt_q == LAST_CYC) state_q <= CMP;
          cnt_q <= cnt_q + 4'd1;
        end
        CMP: begin
          if (better) begin
            best_q  <= sum_q;
            match_q <= MW'(1);
          end else if (tie && (match_q != '1)) begin
            match_q <= match_q + MW'(1);
          end
          if (perm_last) begin
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= FIND;
          end
        end
        FIND: if (perm_done) begin
          w_q     <= '0;
          j_q     <= perm[0];
          cnt_q   <= '0;
          sum_q   <= '0;
          state_q <= ACC;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef JAM_BEST_PERM_EN
  logic [N-1:0][IW-1:0] best_perm_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < N; k++) best_perm_q[k] <= IW'(k);
    end else if (init) begin
      for (int k = 0; k < N; k++) best_perm_q[k] <= IW'(k);
    end else if ((state_q == CMP) && better) begin
      best_perm_q <= perm;
    end
  end

  assign best_perm = best_perm_q;
`endif

  assign cost_bus.W = w_q;
  assign cost_bus.J = j_q;
  assign MatchCount = match_q;
  assign BestCost   = best_q;
  assign Valid      = valid_q;

endmodule

// File: tb/tb_jam_search.sv
// tb/tb_jam_search.sv - randomized bench for jam_search against a brute-force assignment model
`timescale 1ns/1ps
module tb_jam_search;
  logic clk = 1'b0;
  logic rst_n;
  logic start3, start4, start5, mode;
  int   ctab [8][8];
  int   checks = 0;
  int   passed = 0;
  int   mbest, mcnt;
  int   mbp [8];

  always #5 clk = ~clk;

  jam_search_if #(.N(3), .CW(7)) bus3 ();
  jam_search_if #(.N(4), .CW(7)) bus4 ();
  jam_search_if #(.N(5), .CW(7)) bus5 ();

  assign bus3.Cost = 7'(ctab[bus3.W][bus3.J]);
  assign bus4.Cost = 7'(ctab[bus4.W][bus4.J]);
  assign bus5.Cost = 7'(ctab[bus5.W][bus5.J]);

  logic [15:0] match3, match5;
  logic [3:0]  match4;
  logic [9:0]  best3, best4;
  logic [10:0] best5;
  logic        valid3, valid4, valid5;
`ifdef JAM_BEST_PERM_EN
  logic [5:0]  bp3;
  logic [7:0]  bp4;
  logic [14:0] bp5;
`endif

  jam_search #(.N(3), .CW(7), .MW(16)) u3 (
    .CLK(clk), .RST_N(rst_n), .start(start3), .mode(mode), .cost_bus(bus3),
    .MatchCount(match3), .BestCost(best3), .Valid(valid3)
`ifdef JAM_BEST_PERM_EN
    , .best_perm(bp3)
`endif
  );

  jam_search #(.N(4), .CW(7), .MW(4)) u4 (
    .CLK(clk), .RST_N(rst_n), .start(start4), .mode(mode), .cost_bus(bus4),
    .MatchCount(match4), .BestCost(best4), .Valid(valid4)
`ifdef JAM_BEST_PERM_EN
    , .best_perm(bp4)
`endif
  );

  jam_search #(.N(5), .CW(7), .MW(16)) u5 (
    .CLK(clk), .RST_N(rst_n), .start(start5), .mode(mode), .cost_bus(bus5),
    .MatchCount(match5), .BestCost(best5), .Valid(valid5)
`ifdef JAM_BEST_PERM_EN
    , .best_perm(bp5)
`endif
  );

  function automatic int valid_of(input int which);
    case (which)
      3: return int'(valid3);
      4: return int'(valid4);
      default: return int'(valid5);
    endcase
  endfunction

  function automatic int best_of(input int which);
    case (which)
      3: return int'(best3);
      4: return int'(best4);
      default: return int'(best5);
    endcase
  endfunction

  function automatic int match_of(input int which);
    case (which)
      3: return int'(match3);
      4: return int'(match4);
      default: return int'(match5);
    endcase
  endfunction

  function automatic int w_of(input int which);
    case (which)
      3: return int'(bus3.W);
      4: return int'(bus4.W);
      default: return int'(bus5.W);
    endcase
  endfunction

  function automatic int j_of(input int which);
    case (which)
      3: return int'(bus3.J);
      4: return int'(bus4.J);
      default: return int'(bus5.J);
    endcase
  endfunction

`ifdef JAM_BEST_PERM_EN
  function automatic int bp_slot(input int which, input int k);
    case (which)
      3: return int'(bp3[k*2 +: 2]);
      4: return int'(bp4[k*2 +: 2]);
      default: return int'(bp5[k*3 +: 3]);
    endcase
  endfunction
`endif

  // Brute force over every N^N worker->job tuple in lexicographic order, keeping only true permutations.
  task automatic model(input int n, input int md, input int mw);
    int total, x, s;
    int digits [8];
    bit used [8];
    bit ok;
    total = 1;
    for (int k = 0; k < n; k++) total = total * n;
    mcnt  = 0;
    mbest = (md != 0) ? -1 : (1 << 30);
    for (int k = 0; k < 8; k++) mbp[k] = k;
    for (int idx = 0; idx < total; idx++) begin
      x = idx;
      for (int k = n - 1; k >= 0; k--) begin
        digits[k] = x % n;
        x = x / n;
      end
      for (int k = 0; k < 8; k++) used[k] = 1'b0;
      ok = 1'b1;
      s  = 0;
      for (int k = 0; k < n; k++) begin
        if (used[digits[k]]) ok = 1'b0;
        used[digits[k]] = 1'b1;
        s = s + ctab[k][digits[k]];
      end
      if (ok) begin
        if ((md != 0) ? (s > mbest) : (s < mbest)) begin
          mbest = s;
          mcnt  = 1;
          for (int k = 0; k < n; k++) mbp[k] = digits[k];
        end else if (s == mbest) begin
          mcnt = mcnt + 1;
        end
      end
    end
    if (mcnt > (1 << mw) - 1) mcnt = (1 << mw) - 1;
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      3: start3 = v;
      4: start4 = v;
      default: start5 = v;
    endcase
  endtask

  task automatic pulse_start(input int which, input logic md);
    @(negedge clk);
    mode = md;
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    mode = ~md;
  endtask

  task automatic wait_valid(input int which, output bit ok);
    int cyc;
    cyc = 0;
    while ((valid_of(which) == 0) && (cyc < 20000)) begin
      @(negedge clk);
      cyc++;
    end
    ok = (valid_of(which) != 0);
  endtask

  task automatic fill_table(input int maxv);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++)
        ctab[w][j] = $urandom_range(maxv, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start3 = 1'b0; start4 = 1'b0; start5 = 1'b0; mode = 1'b0;
    fill_table(127);
    repeat (3) @(negedge clk);
    for (int u = 3; u <= 5; u++) begin
      checks++; if (valid_of(u) !== 0) $display("FAIL reset_valid u%0d: got %0d want 0", u, valid_of(u)); else passed++;
      checks++; if (best_of(u) !== 0) $display("FAIL reset_best u%0d: got %0d want 0", u, best_of(u)); else passed++;
      checks++; if (match_of(u) !== 0) $display("FAIL reset_match u%0d: got %0d want 0", u, match_of(u)); else passed++;
      checks++; if ((w_of(u) !== 0) || (j_of(u) !== 0))
        $display("FAIL reset_wj u%0d: got W=%0d J=%0d want 0/0", u, w_of(u), j_of(u)); else passed++;
`ifdef JAM_BEST_PERM_EN
      for (int k = 0; k < u; k++) begin
        checks++; if (bp_slot(u, k) !== k) $display("FAIL reset_bp u%0d slot%0d: got %0d want %0d", u, k, bp_slot(u, k), k); else passed++;
      end
`endif
    end
    rst_n = 1'b1;
  endtask

  task automatic test_known_tables();
    bit ok;
    int exp_bp [3];
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) ctab[w][j] = w + j;
    pulse_start(3, 1'b0);
    wait_valid(3, ok);
    checks++; if (!ok) $display("FAIL sum_table_done: Valid stayed 0, want 1"); else passed++;
    checks++; if (best_of(3) !== 6) $display("FAIL sum_table_best: got %0d want 6", best_of(3)); else passed++;
    checks++; if (match_of(3) !== 6) $display("FAIL sum_table_match: got %0d want 6", match_of(3)); else passed++;
    checks++; if ((w_of(3) !== 2) || (j_of(3) !== 0))
      $display("FAIL done_hold_wj: got W=%0d J=%0d want 2/0", w_of(3), j_of(3)); else passed++;

    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) ctab[w][j] = (w == j) ? 0 : 5;
    for (int md = 0; md < 2; md++) begin
      pulse_start(3, 1'(md));
      wait_valid(3, ok);
      checks++; if (!ok) $display("FAIL diag_done mode%0d: Valid stayed 0, want 1", md); else passed++;
      checks++; if (best_of(3) !== ((md != 0) ? 15 : 0))
        $display("FAIL diag_best mode%0d: got %0d want %0d", md, best_of(3), (md != 0) ? 15 : 0); else passed++;
      checks++; if (match_of(3) !== ((md != 0) ? 2 : 1))
        $display("FAIL diag_match mode%0d: got %0d want %0d", md, match_of(3), (md != 0) ? 2 : 1); else passed++;
      exp_bp[0] = (md != 0) ? 1 : 0;
      exp_bp[1] = (md != 0) ? 2 : 1;
      exp_bp[2] = (md != 0) ? 0 : 2;
`ifdef JAM_BEST_PERM_EN
      for (int k = 0; k < 3; k++) begin
        checks++; if (bp_slot(3, k) !== exp_bp[k])
          $display("FAIL diag_bp mode%0d slot%0d: got %0d want %0d", md, k, bp_slot(3, k), exp_bp[k]); else passed++;
      end
`endif
    end
  endtask

  task automatic test_random();
    bit ok;
    int u, md;
    for (int it = 0; it < 6; it++) begin
      u  = (it % 2 == 0) ? 3 : 5;
      md = $urandom_range(1, 0);
      fill_table((it < 3) ? 3 : 127);
      model(u, md, 16);
      pulse_start(u, 1'(md));
      wait_valid(u, ok);
      checks++; if (!ok) $display("FAIL rand_done it%0d: Valid stayed 0, want 1", it); else passed++;
      checks++; if (best_of(u) !== mbest) $display("FAIL rand_best it%0d u%0d: got %0d want %0d", it, u, best_of(u), mbest); else passed++;
      checks++; if (match_of(u) !== mcnt) $display("FAIL rand_match it%0d u%0d: got %0d want %0d", it, u, match_of(u), mcnt); else passed++;
`ifdef JAM_BEST_PERM_EN
      for (int k = 0; k < u; k++) begin
        checks++; if (bp_slot(u, k) !== mbp[k])
          $display("FAIL rand_bp it%0d slot%0d: got %0d want %0d", it, k, bp_slot(u, k), mbp[k]); else passed++;
      end
`endif
    end
  endtask

  task automatic test_max_cost();
    bit ok;
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) ctab[w][j] = 127;
    pulse_start(5, 1'b0);
    wait_valid(5, ok);
    checks++; if (!ok) $display("FAIL maxcost_done: Valid stayed 0, want 1"); else passed++;
    checks++; if (best_of(5) !== 635) $display("FAIL maxcost_best: got %0d want 635", best_of(5)); else passed++;
    checks++; if (match_of(5) !== 120) $display("FAIL maxcost_match: got %0d want 120", match_of(5)); else passed++;
  endtask

  task automatic test_saturate();
    bit ok;
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) ctab[w][j] = 9;
    pulse_start(4, 1'b1);
    wait_valid(4, ok);
    checks++; if (!ok) $display("FAIL sat_done: Valid stayed 0, want 1"); else passed++;
    checks++; if (best_of(4) !== 36) $display("FAIL sat_best: got %0d want 36", best_of(4)); else passed++;
    checks++; if (match_of(4) !== 15) $display("FAIL sat_match: got %0d want 15", match_of(4)); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    fill_table(15);
    model(4, 0, 4);
    pulse_start(4, 1'b0);
    wait_valid(4, ok);
    checks++; if (!ok || (best_of(4) !== mbest) || (match_of(4) !== mcnt))
      $display("FAIL mid_first_run: got valid=%0d best=%0d match=%0d want 1/%0d/%0d", valid_of(4), best_of(4), match_of(4), mbest, mcnt); else passed++;
    pulse_start(4, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ((valid_of(4) !== 0) || (best_of(4) !== 0) || (match_of(4) !== 0) || (w_of(4) !== 0) || (j_of(4) !== 0))
      $display("FAIL mid_async_reset: got valid=%0d best=%0d match=%0d W=%0d J=%0d want all 0",
               valid_of(4), best_of(4), match_of(4), w_of(4), j_of(4)); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(4, 1'b0);
    wait_valid(4, ok);
    checks++; if (!ok) $display("FAIL mid_rerun_done: Valid stayed 0, want 1"); else passed++;
    checks++; if (best_of(4) !== mbest) $display("FAIL mid_rerun_best: got %0d want %0d", best_of(4), mbest); else passed++;
    checks++; if (match_of(4) !== mcnt) $display("FAIL mid_rerun_match: got %0d want %0d", match_of(4), mcnt); else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int b0, c0;
    fill_table(7);
    model(3, 0, 16);
    b0 = mbest;
    c0 = mcnt;
    pulse_start(3, 1'b0);
    repeat (4) @(negedge clk);
    mode = 1'b1;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    wait_valid(3, ok);
    checks++; if (!ok) $display("FAIL ignore_done: Valid stayed 0, want 1"); else passed++;
    checks++; if ((best_of(3) !== b0) || (match_of(3) !== c0))
      $display("FAIL ignore_start: got best=%0d match=%0d want %0d/%0d", best_of(3), match_of(3), b0, c0); else passed++;
    model(3, 1, 16);
    pulse_start(3, 1'b1);
    checks++; if (valid_of(3) !== 0) $display("FAIL rerun_valid_drop: got %0d want 0", valid_of(3)); else passed++;
    wait_valid(3, ok);
    checks++; if (!ok) $display("FAIL rerun_done: Valid stayed 0, want 1"); else passed++;
    checks++; if (best_of(3) !== mbest) $display("FAIL rerun_best: got %0d want %0d", best_of(3), mbest); else passed++;
    checks++; if (match_of(3) !== mcnt) $display("FAIL rerun_match: got %0d want %0d", match_of(3), mcnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_known_tables();
    test_random();
    test_max_cost();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
